// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory req/ack channel plus the decoder-facing
// instruction, retire and next-PC control signals.
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic [2:0]  pc_control;
  logic        alu_zero;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  modport master (
    output imem_addr, imem_req, instr, instr_valid, pc, pc_plus4, fault,
    input  imem_ack, imem_rdata, instr_ack, pc_control, alu_zero, jr_target
  );

  modport slave (
    input  imem_addr, imem_req, instr, instr_valid, pc, pc_plus4, fault,
    output imem_ack, imem_rdata, instr_ack, pc_control, alu_zero, jr_target
  );
endinterface

// File: rtl/instr_fetch.sv
// MIPS instruction fetch unit: fetches the word at pc, holds it for the decoder
// until retired, then resolves the next PC (seq/beq/bne/j/jr) or faults.
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] pc_p4;
  logic [31:0] br_target;
  logic [31:0] npc;
  logic        npc_bad;

  assign pc_p4     = pc_q + 32'd4;
  assign br_target = pc_p4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    npc     = pc_p4;
    npc_bad = 1'b0;
    case (bus.pc_control)
      3'b000:  npc = pc_p4;
      3'b001:  npc = bus.alu_zero ? br_target : pc_p4;
      3'b010:  npc = bus.alu_zero ? pc_p4 : br_target;
      3'b011:  npc = {pc_p4[31:28], instr_q[25:0], 2'b00};
      3'b100:  npc = bus.jr_target;
      default: npc_bad = 1'b1;
    endcase
    if (npc[1:0] != 2'b00) npc_bad = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = req_q;
    valid_d = valid_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        // The request rises one cycle after reset; an ack only counts while it is up.
        if (!req_q) begin
          req_d = 1'b1;
        end else if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.instr_ack) begin
          valid_d = 1'b0;
          if (npc_bad) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = npc;
            req_d   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: state_d = S_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.imem_req    = req_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_p4;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// fetch/retire stream checked against an arithmetic next-PC model.
module tb_instr_fetch;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int          TMO = 16;
  localparam longint      M   = 64'h1_0000_0000;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC    (RPC),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_pc;

  // Next PC from the architectural rules; returns {fault, pc}.
  function automatic logic [32:0] ref_next(input logic [31:0] pc, input logic [2:0] ctl,
                                           input logic zero, input logic [31:0] word,
                                           input logic [31:0] jr);
    longint      p4, tgt;
    logic [31:0] t32;
    p4 = (longint'(pc) + 4) % M;
    case (ctl)
      3'd0: tgt = p4;
      3'd1: tgt = zero  ? p4 + 4 * longint'($signed(word[15:0])) : p4;
      3'd2: tgt = !zero ? p4 + 4 * longint'($signed(word[15:0])) : p4;
      3'd3: tgt = (p4 / (M / 16)) * (M / 16) + 4 * longint'(word[25:0]);
      3'd4: tgt = longint'(jr);
      default: return {1'b1, pc};
    endcase
    tgt = ((tgt % M) + M) % M;
    t32 = 32'(tgt);
    if (tgt % 4 != 0) return {1'b1, pc};
    return {1'b0, t32};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    n_checks++;
    if (!ok) $display("FAIL req_wait: imem_req got 0 want 1 within 40 cycles");
    else n_pass++;
  endtask

  task automatic mem_respond(input int delay, input logic [31:0] word);
    for (int i = 0; i < delay; i++) cyc();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    cyc();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
  endtask

  task automatic retire(input logic [2:0] ctl, input logic zero, input logic [31:0] jr);
    bus.instr_ack  = 1'b1;
    bus.pc_control = ctl;
    bus.alu_zero   = zero;
    bus.jr_target  = jr;
    cyc();
    bus.instr_ack  = 1'b0;
    bus.pc_control = 3'($urandom);
    bus.alu_zero   = 1'($urandom);
    bus.jr_target  = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst  = 1'b0;
    m_pc = RPC;
  endtask

  task automatic test_reset();
    logic [31:0] w;
    rst = 1'b1;
    cyc();
    cyc();
    n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %0h want 0", bus.imem_req); else n_pass++;
    n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_valid: got %0h want 0", bus.instr_valid); else n_pass++;
    n_checks++; if (bus.fault !== 1'b0) $display("FAIL rst_fault: got %0h want 0", bus.fault); else n_pass++;
    n_checks++; if (bus.instr !== 32'h0) $display("FAIL rst_instr: got %0h want 0", bus.instr); else n_pass++;
    n_checks++; if (bus.pc !== RPC) $display("FAIL rst_pc: got %0h want %0h", bus.pc, RPC); else n_pass++;
    n_checks++; if (bus.pc_plus4 !== RPC + 32'd4) $display("FAIL rst_pc_plus4: got %0h want %0h", bus.pc_plus4, RPC + 32'd4); else n_pass++;
    rst = 1'b0;
    cyc();
    n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL first_req: got %0h want 1", bus.imem_req); else n_pass++;
    n_checks++; if (bus.imem_addr !== 32'h0040_0000) $display("FAIL first_addr: got %0h want 400000", bus.imem_addr); else n_pass++;
    w = $urandom;
    mem_respond(0, w);
    n_checks++; if (bus.instr_valid !== 1'b1) $display("FAIL first_valid: got %0h want 1", bus.instr_valid); else n_pass++;
    n_checks++; if (bus.instr !== w) $display("FAIL first_instr: got %0h want %0h", bus.instr, w); else n_pass++;
    n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL first_req_drop: got %0h want 0", bus.imem_req); else n_pass++;
    // A stray memory ack while the word waits for the decoder must not disturb it.
    mem_respond(0, ~w);
    n_checks++; if (bus.instr !== w) $display("FAIL issue_ack_ignored: got %0h want %0h", bus.instr, w); else n_pass++;
    n_checks++; if (bus.instr_valid !== 1'b1) $display("FAIL issue_valid_hold: got %0h want 1", bus.instr_valid); else n_pass++;
    retire(3'b000, 1'b0, 32'h0);
    n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL refetch_req: got %0h want 1", bus.imem_req); else n_pass++;
    n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL retire_valid: got %0h want 0", bus.instr_valid); else n_pass++;
    n_checks++; if (bus.pc !== 32'h0040_0004) $display("FAIL retire_pc: got %0h want 400004", bus.pc); else n_pass++;
  endtask

  task automatic test_sequential();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_req(ok);
      n_checks++; if (bus.imem_addr !== RPC + 32'(4 * i)) $display("FAIL seq_addr%0d: got %0h want %0h", i, bus.imem_addr, RPC + 32'(4 * i)); else n_pass++;
      n_checks++; if (bus.pc_plus4 !== RPC + 32'(4 * i + 4)) $display("FAIL seq_p4_%0d: got %0h want %0h", i, bus.pc_plus4, RPC + 32'(4 * i + 4)); else n_pass++;
      if (i < 2) begin
        mem_respond($urandom_range(0, 2), $urandom);
        retire(3'b000, 1'($urandom), $urandom);
      end
    end
  endtask

  // Continues from pc=0x00400008 with the request raised.
  task automatic test_branch();
    logic [2:0]  ctl [5] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1};
    logic        z   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] imm [5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE};
    logic [31:0] nxt [5] = '{32'h0040_0008, 32'h0040_0008, 32'h0040_000C, 32'h0040_0010, 32'h0040_000C};
    logic [31:0] cur;
    logic [31:0] w;
    bit          ok;
    cur = 32'h0040_0008;
    for (int i = 0; i < 5; i++) begin
      wait_req(ok);
      n_checks++; if (bus.imem_addr !== cur) $display("FAIL br_addr%0d: got %0h want %0h", i, bus.imem_addr, cur); else n_pass++;
      w = {6'h04, 10'($urandom), imm[i]};
      mem_respond($urandom_range(0, 3), w);
      retire(ctl[i], z[i], $urandom);
      n_checks++; if (bus.pc !== nxt[i]) $display("FAIL br_pc%0d: got %0h want %0h", i, bus.pc, nxt[i]); else n_pass++;
      n_checks++; if (bus.fault !== 1'b0) $display("FAIL br_fault%0d: got %0h want 0", i, bus.fault); else n_pass++;
      cur = nxt[i];
    end
  endtask

  // Continues from pc=0x0040000C.
  task automatic test_jump();
    bit ok;
    wait_req(ok);
    mem_respond(0, {6'h02, 26'h010_0010});
    retire(3'b011, 1'b0, 32'h0);
    n_checks++; if (bus.pc !== 32'h0040_0040) $display("FAIL j_pc: got %0h want 400040", bus.pc); else n_pass++;
    wait_req(ok);
    mem_respond(1, $urandom);
    retire(3'b100, 1'b0, 32'hFFFF_FFFC);
    n_checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL jr_addr: got %0h want fffffffc", bus.imem_addr); else n_pass++;
    n_checks++; if (bus.pc_plus4 !== 32'h0) $display("FAIL wrap_p4: got %0h want 0", bus.pc_plus4); else n_pass++;
    wait_req(ok);
    mem_respond(0, $urandom);
    retire(3'b000, 1'b0, 32'h0);
    n_checks++; if (bus.pc !== 32'h0) $display("FAIL wrap_pc: got %0h want 0", bus.pc); else n_pass++;
    n_checks++; if (bus.fault !== 1'b0) $display("FAIL wrap_fault: got %0h want 0", bus.fault); else n_pass++;
  endtask

  task automatic test_fault();
    bit ok;
    do_reset();
    wait_req(ok);
    mem_respond(0, $urandom);
    retire(3'b100, 1'b0, 32'h0040_0102);
    n_checks++; if (bus.fault !== 1'b1) $display("FAIL mis_fault: got %0h want 1", bus.fault); else n_pass++;
    n_checks++; if (bus.pc !== RPC) $display("FAIL mis_pc: got %0h want %0h", bus.pc, RPC); else n_pass++;
    n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL mis_valid: got %0h want 0", bus.instr_valid); else n_pass++;
    mem_respond(3, $urandom);
    cyc();
    n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL halt_req: got %0h want 0", bus.imem_req); else n_pass++;
    n_checks++; if (bus.fault !== 1'b1) $display("FAIL halt_sticky: got %0h want 1", bus.fault); else n_pass++;
    n_checks++; if (bus.pc !== RPC) $display("FAIL halt_pc: got %0h want %0h", bus.pc, RPC); else n_pass++;
    do_reset();
    n_checks++; if (bus.fault !== 1'b0) $display("FAIL clr_fault: got %0h want 0", bus.fault); else n_pass++;
    wait_req(ok);
    n_checks++; if (bus.imem_addr !== RPC) $display("FAIL clr_addr: got %0h want %0h", bus.imem_addr, RPC); else n_pass++;
    mem_respond(0, $urandom);
    retire(3'($urandom_range(5, 7)), 1'($urandom), 32'h0040_0100);
    n_checks++; if (bus.fault !== 1'b1) $display("FAIL rsv_fault: got %0h want 1", bus.fault); else n_pass++;
    n_checks++; if (bus.pc !== RPC) $display("FAIL rsv_pc: got %0h want %0h", bus.pc, RPC); else n_pass++;
    cyc();
    n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL rsv_req: got %0h want 0", bus.imem_req); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    cyc();
    n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL tmo_req: got %0h want 1", bus.imem_req); else n_pass++;
    for (int i = 0; i < TMO - 1; i++) cyc();
    n_checks++; if (bus.fault !== 1'b0) $display("FAIL tmo_early: got %0h want 0", bus.fault); else n_pass++;
    n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL tmo_req_hold: got %0h want 1", bus.imem_req); else n_pass++;
    cyc();
    n_checks++; if (bus.fault !== 1'b1) $display("FAIL tmo_fault: got %0h want 1", bus.fault); else n_pass++;
    n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL tmo_req_drop: got %0h want 0", bus.imem_req); else n_pass++;
    mem_respond(0, 32'hDEAD_BEEF);
    n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL tmo_late_valid: got %0h want 0", bus.instr_valid); else n_pass++;
    n_checks++; if (bus.instr !== 32'h0) $display("FAIL tmo_late_instr: got %0h want 0", bus.instr); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] w;
    do_reset();
    cyc();
    n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL mid_req: got %0h want 1", bus.imem_req); else n_pass++;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    n_checks++; if (bus.imem_req !== 1'b0) $display("FAIL mid_rst_req: got %0h want 0", bus.imem_req); else n_pass++;
    cyc();
    rst            = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    cyc();
    bus.imem_ack   = 1'b0;
    n_checks++; if (bus.instr_valid !== 1'b0) $display("FAIL mid_late_ack: got %0h want 0", bus.instr_valid); else n_pass++;
    n_checks++; if (bus.imem_req !== 1'b1) $display("FAIL mid_refetch: got %0h want 1", bus.imem_req); else n_pass++;
    n_checks++; if (bus.imem_addr !== RPC) $display("FAIL mid_addr: got %0h want %0h", bus.imem_addr, RPC); else n_pass++;
    w = 32'h2108_0001;
    mem_respond(1, w);
    n_checks++; if (bus.instr !== w) $display("FAIL mid_instr: got %0h want %0h", bus.instr, w); else n_pass++;
  endtask

  task automatic test_random();
    logic [32:0] exp;
    logic [31:0] w, jr;
    logic [2:0]  ctl;
    logic        z;
    bit          ok;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      wait_req(ok);
      n_checks++; if (bus.imem_addr !== m_pc) $display("FAIL rnd_addr%0d: got %0h want %0h", i, bus.imem_addr, m_pc); else n_pass++;
      n_checks++; if (bus.pc_plus4 !== m_pc + 32'd4) $display("FAIL rnd_p4_%0d: got %0h want %0h", i, bus.pc_plus4, m_pc + 32'd4); else n_pass++;
      w = $urandom;
      mem_respond($urandom_range(0, 3), w);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) cyc();
      n_checks++; if (bus.instr !== w || bus.instr_valid !== 1'b1) $display("FAIL rnd_instr%0d: got %0h/%0h want %0h/1", i, bus.instr, bus.instr_valid, w); else n_pass++;
      ctl = 3'($urandom_range(0, 4));
      z   = 1'($urandom);
      jr  = $urandom & 32'hFFFF_FFFC;
      exp = ref_next(m_pc, ctl, z, w, jr);
      retire(ctl, z, jr);
      n_checks++; if (bus.pc !== exp[31:0] || bus.fault !== exp[32]) $display("FAIL rnd_npc%0d: got %0h/%0h want %0h/%0h", i, bus.pc, bus.fault, exp[31:0], exp[32]); else n_pass++;
      m_pc = exp[31:0];
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ack  = 1'b0;
    bus.pc_control = 3'b000;
    bus.alu_zero   = 1'b0;
    bus.jr_target  = 32'h0;
    m_pc           = RPC;
    cyc();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_fault();
    test_timeout();
    test_reset_mid_fetch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation got no summary want summary before time limit");
    $fatal(1);
  end

endmodule
